park_lot_controller: RTL and testbench
======================================

// Module: park_lot_controller
// PURPOSE
//  Sequencing controller for the 8-space parking lot. Owns the free-space bitmap (1 = free)
//  and serves car entry and exit requests one at a time. Entry allocates the lowest-index free space.
//  Exit releases a named space. Each served request opens the gate for a timed window.
//  Sits between the gate sensors/keypad and the display/gate actuator logic.
// PARAMETERS
//  GATE_CYCLES  4  cycles gate_open stays high after a served request (legal range 1..255)
// PORTS
//  clk           in   1  system clock, rising edge
//  rst           in   1  asynchronous, active-high reset
//  entry_req     in   1  level; car waiting at entry; held until entry_ack/entry_deny
//  exit_req      in   1  level; car leaving; held until exit_ack/exit_err
//  exit_space    in   3  space index being vacated; stable while exit_req=1
//  entry_ack     out  1  1-cycle pulse; space_granted valid this cycle
//  entry_deny    out  1  1-cycle pulse; lot full, entry refused
//  space_granted out  3  index of allocated space; holds until next allocation
//  exit_ack      out  1  1-cycle pulse; exit_space released
//  exit_err      out  1  1-cycle pulse; exit_space was already free, no state change
//  gate_open     out  1  high for exactly GATE_CYCLES cycles after any ack
//  free_map      out  8  registered free bitmap, bit i = space i free
//  free_count    out  4  popcount(free_map), 0..8
//  full          out  1  free_map == 8'h00
//  empty         out  1  free_map == 8'hFF
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, free_map=8'hFF, free_count=8, empty=1, full=0,
//   space_granted=0, all pulses=0, gate_open=0, prio=0, gate counter=0.
//  FSM states: IDLE, ALLOC, RELEASE, GATE. All outputs registered.
//  IDLE: at each edge evaluate requests:
//   - exit only -> RELEASE; entry only & !full -> ALLOC; entry only & full -> entry_deny pulse, stay IDLE.
//   - both: prio=0 serves exit, prio=1 serves entry. If entry is chosen but full, serve exit instead.
//     After any served contention, prio toggles.
//  ALLOC (1 cycle): pick lowest i with free_map[i]=1. Bit 0 has highest priority.
//   Clear bit i, space_granted=i, entry_ack=1 -> GATE.
//  RELEASE (1 cycle): if free_map[exit_space]=0, set it and pulse exit_ack -> GATE.
//   Otherwise pulse exit_err -> IDLE; free_map is unchanged.
//  Latency: request sampled in IDLE at edge k; ack/err visible after edge k+1; deny visible after edge k.
//  GATE: gate_open=1 for GATE_CYCLES cycles, then IDLE. Requests are ignored while in GATE.
//   Requesters must drop their request within GATE_CYCLES cycles of the ack.
//  free_count, full and empty update in the same cycle as free_map.
//  Only one free_map change per served request. No change in IDLE or GATE.
//  Boundaries:
//   - Allocating the last free space sets full=1 with entry_ack.
//   - Releasing into the 7-occupied state clears full.
//   - Releasing the last occupied space sets empty=1.
//   - exit_err on an empty lot leaves empty=1.
//   - Reset asserted during ALLOC/RELEASE/GATE aborts the operation. No partial bitmap update survives.
// CONFIGURATION
//  PARK_STATS_EN defined: adds output entry_total [15:0] and output exit_total [15:0].
//   Each counter increments on its ack and saturates at 16'hFFFF. Both reset to 0.
//   Deny and err pulses are not counted.
//  PARK_STATS_EN undefined: the ports and counters do not exist. All other behaviour is identical.
// TESTING
//  T1 reset, then entry_req held -> entry_ack 2 cycles later, space_granted=0, free_map=8'hFE, free_count=7, gate_open 4 cycles.
//  T2 8 serial entries -> grants 0..7 in order, full=1. A 9th entry -> entry_deny after 1 cycle, free_map=8'h00 unchanged.
//  T3 lot full, exit_req with exit_space=5 -> exit_ack, free_map=8'h20, full=0. Next entry -> space_granted=5.
//  T4 empty lot, exit_req with exit_space=3 -> exit_err pulse, no gate_open, free_map=8'hFF.
//  T5 entry_req and exit_req rise together (space 2 occupied, prio=0) -> exit served first, then entry.
//   A repeat contest serves entry first.
//  T6 rst pulsed mid-GATE after 3 allocations -> free_map=8'hFF and gate_open=0 immediately; PARK_STATS_EN build: entry_total=0.

Source files
------------

// File: rtl/park_lot_if.sv
// Handshake and status bundle between the parking-lot controller and its gate/keypad/display peers.
// The PARK_STATS_EN macro adds the entry_total/exit_total counters to the bundle.
interface park_lot_if;
  logic        entry_req;
  logic        exit_req;
  logic [2:0]  exit_space;
  logic        entry_ack;
  logic        entry_deny;
  logic [2:0]  space_granted;
  logic        exit_ack;
  logic        exit_err;
  logic        gate_open;
  logic [7:0]  free_map;
  logic [3:0]  free_count;
  logic        full;
  logic        empty;
`ifdef PARK_STATS_EN
  logic [15:0] entry_total;
  logic [15:0] exit_total;
`endif

  modport master (
    output entry_req, exit_req, exit_space,
    input  entry_ack, entry_deny, space_granted, exit_ack, exit_err,
    input  gate_open, free_map, free_count, full, empty
`ifdef PARK_STATS_EN
    , input entry_total, exit_total
`endif
  );

  modport slave (
    input  entry_req, exit_req, exit_space,
    output entry_ack, entry_deny, space_granted, exit_ack, exit_err,
    output gate_open, free_map, free_count, full, empty
`ifdef PARK_STATS_EN
    , output entry_total, exit_total
`endif
  );
endinterface

// File: rtl/park_lot_controller.sv
// 8-space parking lot sequencer: owns the free bitmap, serves one entry/exit at a time, times the gate.
// Define PARK_STATS_EN to add saturating entry_total/exit_total ack counters.
module park_lot_controller #(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic     clk,
  input  logic     rst,
  park_lot_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ALLOC   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] GATE    = 2'd3;

  logic [1:0] state;
  logic       prio;
  logic [7:0] gate_cnt;
  logic [7:0] free_map;
  logic [3:0] free_count;
  logic       full;
  logic       empty;
  logic [2:0] space_granted;
  logic       entry_ack;
  logic       entry_deny;
  logic       exit_ack;
  logic       exit_err;
  logic       gate_open;

  logic [2:0] alloc_idx;
  logic [7:0] alloc_map;
  logic [7:0] release_map;
  logic       exit_occupied;

`ifdef PARK_STATS_EN
  logic [15:0] entry_total;
  logic [15:0] exit_total;
  assign bus.entry_total = entry_total;
  assign bus.exit_total  = exit_total;
`endif

  function automatic logic [3:0] popcount(input logic [7:0] m);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) c = c + 4'(m[i]);
    return c;
  endfunction

  // Scan from the top so the last hit, i.e. the lowest free index, wins.
  always_comb begin
    alloc_idx = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (free_map[i-1]) alloc_idx = 3'(i - 1);
    end
    alloc_map     = free_map & ~(8'b1 << alloc_idx);
    release_map   = free_map | (8'b1 << bus.exit_space);
    exit_occupied = ~free_map[bus.exit_space];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      prio          <= 1'b0;
      gate_cnt      <= '0;
      free_map      <= '1;
      free_count    <= 4'd8;
      full          <= 1'b0;
      empty         <= 1'b1;
      space_granted <= '0;
      entry_ack     <= 1'b0;
      entry_deny    <= 1'b0;
      exit_ack      <= 1'b0;
      exit_err      <= 1'b0;
      gate_open     <= 1'b0;
`ifdef PARK_STATS_EN
      entry_total   <= '0;
      exit_total    <= '0;
`endif
    end else begin
      entry_ack  <= 1'b0;
      entry_deny <= 1'b0;
      exit_ack   <= 1'b0;
      exit_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.entry_req && bus.exit_req) begin
            // A full lot makes an entry win pointless, so exit is served and prio still flips.
            prio  <= ~prio;
            state <= (prio && !full) ? ALLOC : RELEASE;
          end else if (bus.exit_req) begin
            state <= RELEASE;
          end else if (bus.entry_req) begin
            if (full) entry_deny <= 1'b1;
            else      state      <= ALLOC;
          end
        end
        ALLOC: begin
          free_map      <= alloc_map;
          free_count    <= popcount(alloc_map);
          full          <= (alloc_map == 8'h00);
          empty         <= (alloc_map == 8'hFF);
          space_granted <= alloc_idx;
          entry_ack     <= 1'b1;
          gate_open     <= 1'b1;
          gate_cnt      <= 8'(GATE_CYCLES);
          state         <= GATE;
`ifdef PARK_STATS_EN
          if (entry_total != 16'hFFFF) entry_total <= entry_total + 16'd1;
`endif
        end
        RELEASE: begin
          if (exit_occupied) begin
            free_map   <= release_map;
            free_count <= popcount(release_map);
            full       <= (release_map == 8'h00);
            empty      <= (release_map == 8'hFF);
            exit_ack   <= 1'b1;
            gate_open  <= 1'b1;
            gate_cnt   <= 8'(GATE_CYCLES);
            state      <= GATE;
`ifdef PARK_STATS_EN
            if (exit_total != 16'hFFFF) exit_total <= exit_total + 16'd1;
`endif
          end else begin
            exit_err <= 1'b1;
            state    <= IDLE;
          end
        end
        GATE: begin
          if (gate_cnt <= 8'd1) begin
            gate_open <= 1'b0;
            gate_cnt  <= '0;
            state     <= IDLE;
          end else begin
            gate_cnt <= gate_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.free_map      = free_map;
  assign bus.free_count    = free_count;
  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.space_granted = space_granted;
  assign bus.entry_ack     = entry_ack;
  assign bus.entry_deny    = entry_deny;
  assign bus.exit_ack      = exit_ack;
  assign bus.exit_err      = exit_err;
  assign bus.gate_open     = gate_open;

endmodule

// File: tb/tb_park_lot_controller.sv
// Directed bench for park_lot_controller: entry/exit handshakes, gate timing, full/empty edges, contention, reset abort.
module tb_park_lot_controller;

  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  park_lot_if bus ();

  park_lot_controller #(.GATE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.entry_req  = 1'b0;
    bus.exit_req   = 1'b0;
    bus.exit_space = 3'd0;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  // Ack has just been seen: gate stays high 3 more edges, drops on the 4th.
  task automatic wait_gate();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gate_hold", 16'(bus.gate_open), 16'd1);
    end
    tick();
    chk("gate_drop", 16'(bus.gate_open), 16'd0);
  endtask

  task automatic do_entry(input logic [2:0] idx);
    bus.entry_req = 1'b1;
    tick();
    chk("entry_ack_early", 16'(bus.entry_ack), 16'd0);
    tick();
    chk("entry_ack", 16'(bus.entry_ack), 16'd1);
    chk("space_granted", 16'(bus.space_granted), 16'(idx));
    chk("gate_open_ack", 16'(bus.gate_open), 16'd1);
    bus.entry_req = 1'b0;
    wait_gate();
  endtask

  task automatic do_exit(input logic [2:0] sp, input logic ok);
    bus.exit_space = sp;
    bus.exit_req   = 1'b1;
    tick();
    tick();
    chk("exit_ack", 16'(bus.exit_ack), 16'(ok));
    chk("exit_err", 16'(bus.exit_err), 16'(!ok));
    bus.exit_req = 1'b0;
    if (ok) begin
      wait_gate();
    end else begin
      chk("gate_err", 16'(bus.gate_open), 16'd0);
      tick();
      chk("gate_err2", 16'(bus.gate_open), 16'd0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.entry_req  = 1'b0;
    bus.exit_req   = 1'b0;
    bus.exit_space = 3'd0;
    tick();
    do_reset();

    chk("rst_map", 16'(bus.free_map), 16'hFF);
    chk("rst_count", 16'(bus.free_count), 16'd8);
    chk("rst_empty", 16'(bus.empty), 16'd1);
    chk("rst_full", 16'(bus.full), 16'd0);
    chk("rst_gate", 16'(bus.gate_open), 16'd0);
    chk("rst_granted", 16'(bus.space_granted), 16'd0);

    // T1
    do_entry(3'd0);
    chk("t1_map", 16'(bus.free_map), 16'hFE);
    chk("t1_count", 16'(bus.free_count), 16'd7);
    chk("t1_empty", 16'(bus.empty), 16'd0);

    // T2: remaining seven entries, then a denied ninth
    for (int i = 1; i < 8; i++) do_entry(3'(i));
    chk("t2_map", 16'(bus.free_map), 16'h00);
    chk("t2_full", 16'(bus.full), 16'd1);
    chk("t2_count", 16'(bus.free_count), 16'd0);
`ifdef PARK_STATS_EN
    chk("t2_entry_total", bus.entry_total, 16'd8);
`endif
    bus.entry_req = 1'b1;
    tick();
    chk("t2_deny", 16'(bus.entry_deny), 16'd1);
    chk("t2_deny_map", 16'(bus.free_map), 16'h00);
    chk("t2_deny_gate", 16'(bus.gate_open), 16'd0);
    bus.entry_req = 1'b0;
    tick();
    chk("t2_deny_pulse", 16'(bus.entry_deny), 16'd0);

    // T3
    do_exit(3'd5, 1'b1);
    chk("t3_map", 16'(bus.free_map), 16'h20);
    chk("t3_full", 16'(bus.full), 16'd0);
    chk("t3_count", 16'(bus.free_count), 16'd1);
    do_entry(3'd5);
    chk("t3_map2", 16'(bus.free_map), 16'h00);
    chk("t3_full2", 16'(bus.full), 16'd1);

    // T4: exit_err on empty lot, then last-occupied release sets empty
    do_reset();
    do_exit(3'd3, 1'b0);
    chk("t4_map", 16'(bus.free_map), 16'hFF);
    chk("t4_empty", 16'(bus.empty), 16'd1);
    do_entry(3'd0);
    chk("t4_empty_clr", 16'(bus.empty), 16'd0);
    do_exit(3'd0, 1'b1);
    chk("t4_empty_set", 16'(bus.empty), 16'd1);
    chk("t4_count", 16'(bus.free_count), 16'd8);

    // T5: contention, prio starts at 0 after reset
    do_reset();
    for (int i = 0; i < 3; i++) do_entry(3'(i));
    chk("t5_setup", 16'(bus.free_map), 16'hF8);
    bus.exit_space = 3'd2;
    bus.exit_req   = 1'b1;
    bus.entry_req  = 1'b1;
    tick();
    tick();
    chk("t5a_exit_ack", 16'(bus.exit_ack), 16'd1);
    chk("t5a_entry_ack", 16'(bus.entry_ack), 16'd0);
    chk("t5a_map", 16'(bus.free_map), 16'hFC);
    bus.exit_req = 1'b0;
    wait_gate();
    tick();
    chk("t5a_entry_wait", 16'(bus.entry_ack), 16'd0);
    tick();
    chk("t5a_entry_ack2", 16'(bus.entry_ack), 16'd1);
    chk("t5a_granted", 16'(bus.space_granted), 16'd2);
    bus.entry_req = 1'b0;
    wait_gate();
    bus.exit_req  = 1'b1;
    bus.entry_req = 1'b1;
    tick();
    tick();
    chk("t5b_entry_ack", 16'(bus.entry_ack), 16'd1);
    chk("t5b_exit_ack", 16'(bus.exit_ack), 16'd0);
    chk("t5b_granted", 16'(bus.space_granted), 16'd3);
    chk("t5b_map", 16'(bus.free_map), 16'hF0);
    bus.entry_req = 1'b0;
    wait_gate();
    tick();
    chk("t5b_exit_wait", 16'(bus.exit_ack), 16'd0);
    tick();
    chk("t5b_exit_ack2", 16'(bus.exit_ack), 16'd1);
    chk("t5b_map2", 16'(bus.free_map), 16'hF4);
    bus.exit_req = 1'b0;
    wait_gate();

    // T6: reset mid-GATE after the third allocation
    do_reset();
    do_entry(3'd0);
    do_entry(3'd1);
    bus.entry_req = 1'b1;
    tick();
    tick();
    chk("t6_ack", 16'(bus.entry_ack), 16'd1);
    bus.entry_req = 1'b0;
    tick();
    chk("t6_gate_before", 16'(bus.gate_open), 16'd1);
    rst = 1'b1;
    #1;
    chk("t6_map", 16'(bus.free_map), 16'hFF);
    chk("t6_gate", 16'(bus.gate_open), 16'd0);
    chk("t6_count", 16'(bus.free_count), 16'd8);
    chk("t6_empty", 16'(bus.empty), 16'd1);
`ifdef PARK_STATS_EN
    chk("t6_entry_total", bus.entry_total, 16'd0);
`endif
    #2;
    rst = 1'b0;
    tick();
    do_entry(3'd0);
    chk("t6_after_map", 16'(bus.free_map), 16'hFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
